// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encodings,
// the NOP word presented when nothing is held, and the default reset PC.
package instr_fetch_pkg;

  typedef logic [31:0] word_t;

  localparam logic [2:0] FS_RESET = 3'd0;
  localparam logic [2:0] FS_REQ   = 3'd1;
  localparam logic [2:0] FS_HOLD  = 3'd2;
  localparam logic [2:0] FS_HALT  = 3'd3;
  localparam logic [2:0] FS_FAULT = 3'd4;

  localparam word_t NOP_INSTR        = 32'h0000_0013;
  localparam word_t DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic is_aligned(input word_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory read port and the core-facing
// fetch/retire handshake. master = fetch stage, slave = memory + core.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  logic  imem_req;
  word_t imem_addr;
  logic  imem_ack;
  word_t imem_rdata;

  word_t pc;
  word_t instr;
  logic  instr_valid;
  word_t next_pc;
  logic  next_pc_valid;
  logic  halt;
  logic  halted;
  logic  fault;
  word_t retired;

  modport master (
    output imem_req, imem_addr, pc, instr, instr_valid, halted, fault, retired,
    input  imem_ack, imem_rdata, next_pc, next_pc_valid, halt
  );

  modport slave (
    input  imem_req, imem_addr, pc, instr, instr_valid, halted, fault, retired,
    output imem_ack, imem_rdata, next_pc, next_pc_valid, halt
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads instruction memory with a
// req/ack handshake and holds pc/instr stable until the core retires it.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter word_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          CLK,
  input  logic          RST_X,
  instr_fetch_if.master bus
);

  logic [2:0] state;
  word_t      pc_q;
  word_t      instr_q;
  word_t      retired_q;
  logic       valid_q;
  logic       halted_q;
  logic       fault_q;

  // Request decodes straight from state so an async reset drops it at once.
  assign bus.imem_req    = (state == FS_REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.pc          = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.retired     = retired_q;

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      state     <= FS_RESET;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      retired_q <= '0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      case (state)
        FS_RESET: state <= FS_REQ;

        FS_REQ: begin
          if (bus.imem_ack) begin
            instr_q <= bus.imem_rdata;
            valid_q <= 1'b1;
            state   <= FS_HOLD;
          end
        end

        FS_HOLD: begin
          // Halt outranks retirement: a halting instruction is not counted.
          if (bus.halt) begin
            valid_q  <= 1'b0;
            halted_q <= 1'b1;
            instr_q  <= NOP_INSTR;
            state    <= FS_HALT;
          end else if (bus.next_pc_valid) begin
            pc_q      <= bus.next_pc;
            valid_q   <= 1'b0;
            instr_q   <= NOP_INSTR;
            retired_q <= retired_q + 32'd1;
            if (is_aligned(bus.next_pc)) begin
              state <= FS_REQ;
            end else begin
              fault_q <= 1'b1;
              state   <= FS_FAULT;
            end
          end
        end

        FS_HALT, FS_FAULT: state <= state;

        default: state <= FS_FAULT;
      endcase
    end
  end

endmodule
